// File: rtl/bsg_link_pkg.sv
// Shared BSG link definitions: beat/word widths, credit defaults, transmit FSM states.
// Pure declarations; no timing or flow-control behaviour lives here.
package bsg_link_pkg;

    localparam int LINK_BEAT_W       = 8;
    localparam int LINK_WORD_W       = 16;
    localparam int CORE_WORD_W       = 32;
    localparam int CREDIT_INIT_DEF   = 8;
    localparam int CREDIT_RETURN_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        B0,
        B1,
        WAIT_HI,
        B2,
        B3
    } tx_state_e;

endpackage

// File: rtl/bsg_upstream_tx_fifo.sv
// Core-word buffer for the upstream transmitter; exposes head word and low beat of the next word.
// Latency: written word visible at head the cycle after push.
// Backpressure: push ignored when full; full/empty from registered wrap-bit pointers.
module bsg_upstream_tx_fifo
    import bsg_link_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [CORE_WORD_W-1:0] din,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic                   two,
    output logic [CORE_WORD_W-1:0] dout,
    output logic [LINK_BEAT_W-1:0] dout_next_beat
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [CORE_WORD_W-1:0] mem [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          count;
    logic [AW-1:0]          rd_next_idx;

    assign count          = wr_ptr - rd_ptr;
    assign full           = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty          = (wr_ptr == rd_ptr);
    assign two            = (count > PW'(1));
    assign rd_next_idx    = rd_ptr[AW-1:0] + AW'(1);
    assign dout           = mem[rd_ptr[AW-1:0]];
    assign dout_next_beat = mem[rd_next_idx][LINK_BEAT_W-1:0];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/bsg_upstream_tx.sv
// Upstream link transmitter: 32-bit core words out as four 8-bit beats, two link words per core word.
// Latency: word accepted at cycle t into an idle, credited block shows its first beat at t+2.
// Backpressure: core_ready_out follows FIFO space; one credit consumed per link word, refilled by token edges.
module bsg_upstream_tx
    import bsg_link_pkg::*;
#(
    parameter int CREDIT_INIT   = CREDIT_INIT_DEF,
    parameter int CREDIT_RETURN = CREDIT_RETURN_DEF,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   core_valid_in,
    input  logic [CORE_WORD_W-1:0] core_data_in,
    output logic                   core_ready_out,
    output logic                   io_valid_out,
    output logic [LINK_BEAT_W-1:0] io_data_out,
    input  logic                   io_token_in,
    output logic [3:0]             credit_cnt,
    output logic                   credit_err
);

    tx_state_e              state;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_two;
    logic [CORE_WORD_W-1:0] head;
    logic [LINK_BEAT_W-1:0] next_beat0;
    logic                   push;
    logic                   pop;
    logic                   consume;
    logic                   credit_avail;
    logic                   token_q;
    logic                   credit_ret;
    logic [4:0]             credit_sum;

    assign core_ready_out = !rst && !fifo_full;
    assign push           = core_valid_in && core_ready_out;
    assign pop            = (state == B3);
    assign credit_avail   = (credit_cnt != 4'd0);
    assign credit_ret     = io_token_in ^ token_q;

    bsg_upstream_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .push           (push),
        .din            (core_data_in),
        .pop            (pop),
        .full           (fifo_full),
        .empty          (fifo_empty),
        .two            (fifo_two),
        .dout           (head),
        .dout_next_beat (next_beat0)
    );

    // A credit is taken exactly when the FSM launches the first beat of a link word.
    always_comb begin
        consume = 1'b0;
        case (state)
            IDLE:        consume = credit_avail && !fifo_empty;
            B1, WAIT_HI: consume = credit_avail;
            B3:          consume = credit_avail && fifo_two;
            default:     consume = 1'b0;
        endcase
    end

    assign credit_sum = {1'b0, credit_cnt} + (credit_ret ? 5'(CREDIT_RETURN) : 5'd0)
                      - {4'd0, consume};

    always_ff @(posedge clk) begin
        if (rst) begin
            token_q    <= 1'b0;
            credit_cnt <= 4'(CREDIT_INIT);
            credit_err <= 1'b0;
        end else begin
            token_q <= io_token_in;
            if (credit_sum > 5'(CREDIT_INIT)) begin
                credit_cnt <= 4'(CREDIT_INIT);
                credit_err <= 1'b1;
            end else begin
                credit_cnt <= credit_sum[3:0];
            end
        end
    end

    // Outputs are registered together with the state, so each state shows its own beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            io_valid_out <= 1'b0;
            io_data_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    io_valid_out <= consume;
                    if (consume) begin
                        state       <= B0;
                        io_data_out <= head[7:0];
                    end
                end
                B0: begin
                    state        <= B1;
                    io_valid_out <= 1'b1;
                    io_data_out  <= head[15:8];
                end
                B1, WAIT_HI: begin
                    io_valid_out <= consume;
                    if (consume) begin
                        state       <= B2;
                        io_data_out <= head[23:16];
                    end else begin
                        state <= WAIT_HI;
                    end
                end
                B2: begin
                    state        <= B3;
                    io_valid_out <= 1'b1;
                    io_data_out  <= head[31:24];
                end
                B3: begin
                    io_valid_out <= consume;
                    if (consume) begin
                        state       <= B0;
                        io_data_out <= next_beat0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    io_valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
